uart_tx_fifo_param: RTL

- Parametrised next-generation UART transmitter with an integrated transmit FIFO.
- Supports runtime-selectable frame formats:
  - 5–9 data bits;
  - parity none, even, odd or stick;
  - 1 or 2 stop bits;
  - break generation.
- Sits between the host register interface and the TX pad, and is paced by the shared baud generator's bit tick.

---
 rtl/uart_tx_fifo_param.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with integrated transmit FIFO.
// Runtime frame format: 5-9 data bits, parity, 1/2 stop bits, break.
module uart_tx_fifo_param #(
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             TX_TICK,
    input  logic             WEN,
    input  logic [8:0]       WDATA,
    input  logic [3:0]       DATA_BITS,
    input  logic             PARITY_EN,
    input  logic             PARITY_ODD,
    input  logic             PARITY_STICK,
    input  logic             STOP2,
    input  logic             BREAK_REQ,
    output logic             TX,
    output logic             FULL,
    output logic             EMPTY,
    output logic [LVL_W-1:0] LEVEL,
    output logic             OVERFLOW,
    output logic             TX_DONE,
    output logic             TX_BUSY
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_BREAK
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [8:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [LVL_W-1:0] level;
    logic             full;
    logic             empty;
    logic             wr_ok;
    logic             pop;
    logic             ovf_q;
    logic [8:0]       data_q;
    logic [3:0]       nbits_q;
    logic [3:0]       nbits_in;
    logic [3:0]       cnt;
    logic [3:0]       cnt_nx;
    logic             par_en_q;
    logic             par_odd_q;
    logic             par_stick_q;
    logic             stop2_q;
    logic             tx_q;
    logic             tx_nx;
    logic             done_q;
    logic             done_nx;
    logic             par_bit;
    logic             fin;

    // Full is judged before any same-cycle pop, so a write at full is lost.
    assign full  = (level == LVL_W'(FIFO_DEPTH));
    assign empty = (level == '0);
    assign wr_ok = WEN & ~full;

    // Out-of-range data widths clamp to the nearest legal width.
    always_comb begin
        nbits_in = DATA_BITS;
        if (DATA_BITS < 4'd5) begin
            nbits_in = 4'd5;
        end else if (DATA_BITS > 4'd9) begin
            nbits_in = 4'd9;
        end
    end

    // Parity over the active data bits of the frame in flight.
    always_comb begin
        par_bit = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (4'(i) < nbits_q) begin
                par_bit = par_bit ^ data_q[i];
            end
        end
        if (par_odd_q) begin
            par_bit = ~par_bit;
        end
        if (par_stick_q) begin
            par_bit = par_odd_q;
        end
    end

    // FIFO storage; contents need no reset since level gates all reads.
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem[wptr] <= WDATA;
        end
    end

    // FIFO pointers, occupancy and the overflow pulse.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            level <= level + LVL_W'(wr_ok) - LVL_W'(pop);
            ovf_q <= WEN & full;
        end
    end

    // Next state and next TX bit; everything moves only on a bit tick.
    always_comb begin
        state_nx = state;
        tx_nx    = tx_q;
        cnt_nx   = cnt;
        pop      = 1'b0;
        done_nx  = 1'b0;
        fin      = 1'b0;
        if (TX_TICK) begin
            unique case (state)
                S_IDLE: begin
                    if (BREAK_REQ) begin
                        state_nx = S_BREAK;
                        tx_nx    = 1'b0;
                    end else if (!empty) begin
                        pop      = 1'b1;
                        state_nx = S_START;
                        tx_nx    = 1'b0;
                    end
                end
                S_START: begin
                    tx_nx    = data_q[0];
                    cnt_nx   = '0;
                    state_nx = S_DATA;
                end
                S_DATA: begin
                    if (cnt == nbits_q - 4'd1) begin
                        if (par_en_q) begin
                            state_nx = S_PARITY;
                            tx_nx    = par_bit;
                        end else begin
                            state_nx = S_STOP1;
                            tx_nx    = 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt + 4'd1;
                        tx_nx  = data_q[cnt_nx];
                    end
                end
                S_PARITY: begin
                    state_nx = S_STOP1;
                    tx_nx    = 1'b1;
                end
                S_STOP1: begin
                    if (stop2_q) begin
                        state_nx = S_STOP2;
                        tx_nx    = 1'b1;
                    end else begin
                        fin = 1'b1;
                    end
                end
                S_STOP2: begin
                    fin = 1'b1;
                end
                S_BREAK: begin
                    if (!BREAK_REQ) begin
                        state_nx = S_IDLE;
                        tx_nx    = 1'b1;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                    tx_nx    = 1'b1;
                end
            endcase
            if (fin) begin
                done_nx = 1'b1;
                if (BREAK_REQ) begin
                    state_nx = S_BREAK;
                    tx_nx    = 1'b0;
                end else if (!empty) begin
                    pop      = 1'b1;
                    state_nx = S_START;
                    tx_nx    = 1'b0;
                end else begin
                    state_nx = S_IDLE;
                    tx_nx    = 1'b1;
                end
            end
        end
    end

    // State, TX bit and frame config; config is captured at each pop.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= S_IDLE;
            tx_q        <= 1'b1;
            cnt         <= '0;
            done_q      <= 1'b0;
            data_q      <= '0;
            nbits_q     <= 4'd5;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            par_stick_q <= 1'b0;
            stop2_q     <= 1'b0;
        end else begin
            state  <= state_nx;
            tx_q   <= tx_nx;
            cnt    <= cnt_nx;
            done_q <= done_nx;
            if (pop) begin
                data_q      <= mem[rptr];
                nbits_q     <= nbits_in;
                par_en_q    <= PARITY_EN;
                par_odd_q   <= PARITY_ODD;
                par_stick_q <= PARITY_STICK;
                stop2_q     <= STOP2;
            end
        end
    end

    assign TX       = tx_q;
    assign FULL     = full;
    assign EMPTY    = empty;
    assign LEVEL    = level;
    assign OVERFLOW = ovf_q;
    assign TX_DONE  = done_q;
    assign TX_BUSY  = (state != S_IDLE) | ~empty;

endmodule
